// File: rtl/zbus_strobe.sv
// ZX-bus strobe front end: synchronizes and deglitches the Z80 I/O strobes and
// turns each filtered bus cycle into one single-clock read or write strobe.
module zbus_strobe #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 2,
    parameter int ADDR_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ziorq_n,
    input  logic              zrd_n,
    input  logic              zwr_n,
    input  logic              port_sel,
    input  logic [ADDR_W-1:0] za_low,
    input  logic [7:0]        zd_in,
    output logic              rd_stb,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] stb_addr,
    output logic [7:0]        stb_data,
    output logic              cyc_active,
    output logic              cyc_err
);

    localparam int SYNC_W = 4 + ADDR_W + 8;
    localparam int CNT_W  = (FILT_LEN < 1) ? 1 : $clog2(FILT_LEN + 1);
    localparam int SETTLE = SYNC_STAGES + FILT_LEN;
    localparam int SET_W  = $clog2(SETTLE + 1);

    localparam logic [SYNC_W-1:0] SYNC_IDLE  = {3'b111, 1'b0, {(ADDR_W + 8){1'b0}}};
    localparam logic [CNT_W-1:0]  FILT_LAST  = CNT_W'(FILT_LEN - 1);
    localparam logic [SET_W-1:0]  SETTLE_CNT = SET_W'(SETTLE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        WRITE    = 2'd2,
        WAIT_END = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer: all async pins travel together as one vector.
    // ------------------------------------------------------------------
    logic [SYNC_W-1:0]                  pins;
    logic [SYNC_STAGES-1:0][SYNC_W-1:0] sync_q;
    logic [SYNC_W-1:0]                  sync_out;

    assign pins = {ziorq_n, zrd_n, zwr_n, port_sel, za_low, zd_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{SYNC_IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    logic              iorq_s;
    logic              rd_s;
    logic              wr_s;
    logic              sel_s;
    logic [ADDR_W-1:0] za_s;
    logic [7:0]        zd_s;
    logic              raw_rd;
    logic              raw_wr;

    assign iorq_s = sync_out[SYNC_W-1];
    assign rd_s   = sync_out[SYNC_W-2];
    assign wr_s   = sync_out[SYNC_W-3];
    assign sel_s  = sync_out[SYNC_W-4];
    assign za_s   = sync_out[8 +: ADDR_W];
    assign zd_s   = sync_out[7:0];

    assign raw_rd = !iorq_s && !rd_s && sel_s;
    assign raw_wr = !iorq_s && !wr_s && sel_s;

    // ------------------------------------------------------------------
    // Deglitch filters; bit 0 is the read request, bit 1 the write request.
    // ------------------------------------------------------------------
    logic [1:0] raw_req;
    logic [1:0] filt_req;

    assign raw_req = {raw_wr, raw_rd};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic [CNT_W-1:0] cnt_q;
            logic             f_q;

            // The flag flips on the edge where the disagreement run reaches FILT_LEN.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                    f_q   <= 1'b0;
                end else if (raw_req[gi] == f_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == FILT_LAST) begin
                    cnt_q <= '0;
                    f_q   <= ~f_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign filt_req[gi] = f_q;
        end
    endgenerate

    logic f_rd;
    logic f_wr;

    assign f_rd = filt_req[0];
    assign f_wr = filt_req[1];

    // ------------------------------------------------------------------
    // After reset the filters start inactive even if a cycle is under way;
    // WAIT_END is held until the pipeline has seen the real pin state.
    // ------------------------------------------------------------------
    logic [SET_W-1:0] settle_q;
    logic             settled;

    assign settled = (settle_q == SETTLE_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q <= '0;
        end else if (!settled) begin
            settle_q <= settle_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Cycle FSM with registered strobes.
    // ------------------------------------------------------------------
    state_t state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_END;
            rd_stb     <= 1'b0;
            wr_stb     <= 1'b0;
            cyc_err    <= 1'b0;
            cyc_active <= 1'b0;
        end else begin
            rd_stb  <= 1'b0;
            wr_stb  <= 1'b0;
            cyc_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (f_rd && f_wr) begin
                        state_q    <= WAIT_END;
                        cyc_err    <= 1'b1;
                        cyc_active <= 1'b1;
                    end else if (f_rd) begin
                        state_q    <= READ;
                        rd_stb     <= 1'b1;
                        cyc_active <= 1'b1;
                    end else if (f_wr) begin
                        state_q    <= WRITE;
                        cyc_active <= 1'b1;
                    end
                end
                READ: begin
                    if (f_wr) begin
                        state_q <= WAIT_END;
                        cyc_err <= 1'b1;
                    end else if (!f_rd) begin
                        state_q    <= IDLE;
                        cyc_active <= 1'b0;
                    end
                end
                WRITE: begin
                    if (f_rd) begin
                        state_q <= WAIT_END;
                        cyc_err <= 1'b1;
                    end else if (!f_wr) begin
                        state_q    <= IDLE;
                        wr_stb     <= 1'b1;
                        cyc_active <= 1'b0;
                    end
                end
                default: begin
                    if (settled && !f_rd && !f_wr) begin
                        state_q    <= IDLE;
                        cyc_active <= 1'b0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Address / data capture.
    // ------------------------------------------------------------------
    logic              leave_idle;
    logic [ADDR_W-1:0] stb_addr_d;
    logic [7:0]        stb_data_d;

    assign leave_idle = (state_q == IDLE) && (f_rd || f_wr);

    always_comb begin
        stb_addr_d = stb_addr;
        stb_data_d = stb_data;
        if (leave_idle) begin
            stb_addr_d = za_s;
        end
        // Track data through the whole write so the last low-WR sample wins.
        if ((state_q == WRITE) && raw_wr) begin
            stb_data_d = zd_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_addr <= '0;
            stb_data <= '0;
        end else begin
            stb_addr <= stb_addr_d;
            stb_data <= stb_data_d;
        end
    end

endmodule

// File: tb/tb_zbus_strobe.sv
// Directed bench for zbus_strobe: bus cycles driven on the falling clock edge,
// strobes observed on the falling edge and checked against hand-derived timing.
module tb_zbus_strobe;

    logic       clk = 1'b0;
    logic       rst;
    logic       ziorq_n;
    logic       zrd_n;
    logic       zwr_n;
    logic       port_sel;
    logic [1:0] za_low;
    logic [7:0] zd_in;
    logic       rd_stb;
    logic       wr_stb;
    logic [1:0] stb_addr;
    logic [7:0] stb_data;
    logic       cyc_active;
    logic       cyc_err;

    zbus_strobe #(
        .SYNC_STAGES(2),
        .FILT_LEN   (2),
        .ADDR_W     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ziorq_n   (ziorq_n),
        .zrd_n     (zrd_n),
        .zwr_n     (zwr_n),
        .port_sel  (port_sel),
        .za_low    (za_low),
        .zd_in     (zd_in),
        .rd_stb    (rd_stb),
        .wr_stb    (wr_stb),
        .stb_addr  (stb_addr),
        .stb_data  (stb_data),
        .cyc_active(cyc_active),
        .cyc_err   (cyc_err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         idx;
    int         rd_cnt;
    int         wr_cnt;
    int         err_cnt;
    int         ovl_cnt;
    int         rd_idx;
    int         wr_idx;
    int         err_idx;
    logic       act_seen;
    logic [1:0] addr_at_stb;
    logic [7:0] data_at_wr;

    // Advance to the next falling edge and log what the DUT produced.
    task automatic tick();
        @(negedge clk);
        idx++;
        if (rd_stb) begin
            rd_cnt++;
            rd_idx      = idx;
            addr_at_stb = stb_addr;
        end
        if (wr_stb) begin
            wr_cnt++;
            wr_idx      = idx;
            addr_at_stb = stb_addr;
            data_at_wr  = stb_data;
        end
        if (cyc_err) begin
            err_cnt++;
            err_idx = idx;
        end
        if (rd_stb && wr_stb) ovl_cnt++;
        if (cyc_active) act_seen = 1'b1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_log();
        idx         = 0;
        rd_cnt      = 0;
        wr_cnt      = 0;
        err_cnt     = 0;
        ovl_cnt     = 0;
        rd_idx      = -1;
        wr_idx      = -1;
        err_idx     = -1;
        act_seen    = 1'b0;
        addr_at_stb = 2'bxx;
        data_at_wr  = 8'hxx;
    endtask

    task automatic bus_idle();
        ziorq_n  = 1'b1;
        zrd_n    = 1'b1;
        zwr_n    = 1'b1;
        port_sel = 1'b0;
    endtask

    task automatic test_reset();
        bus_idle();
        za_low = 2'b11;
        zd_in  = 8'hFF;
        rst    = 1'b1;
        clear_log();
        ticks(3);
        n_cmp++;
        if ({rd_stb, wr_stb, cyc_err, cyc_active} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 0000", {rd_stb, wr_stb, cyc_err, cyc_active});
        end
        n_cmp++;
        if (stb_addr !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_addr: got %h expected 0", stb_addr);
        end
        n_cmp++;
        if (stb_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data: got %h expected 00", stb_data);
        end
        rst = 1'b0;
        clear_log();
        ticks(8);
        n_cmp++;
        if (rd_cnt + wr_cnt + err_cnt !== 0) begin
            n_bad++;
            $display("FAIL reset_quiet: got %0d strobes expected 0", rd_cnt + wr_cnt + err_cnt);
        end
        $display("reset: released, bus idle");
    endtask

    task automatic test_write();
        clear_log();
        ziorq_n  = 1'b0;
        zwr_n    = 1'b0;
        port_sel = 1'b1;
        za_low   = 2'b01;
        zd_in    = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (idx == 4) begin
                n_cmp++;
                if (cyc_active !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wr_active_early: got %b expected 0", cyc_active);
                end
            end
            if (idx == 5) begin
                n_cmp++;
                if (cyc_active !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wr_active_start: got %b expected 1", cyc_active);
                end
            end
        end
        n_cmp++;
        if (wr_cnt !== 0 || cyc_active !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_hold: got wr_cnt=%0d active=%b expected 0/1", wr_cnt, cyc_active);
        end
        bus_idle();
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (idx == 4) begin
                n_cmp++;
                if (cyc_active !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wr_active_end: got %b expected 1", cyc_active);
                end
            end
            if (idx == 5) begin
                n_cmp++;
                if (cyc_active !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wr_active_drop: got %b expected 0", cyc_active);
                end
            end
        end
        n_cmp++;
        if (wr_cnt !== 1 || wr_idx !== 5) begin
            n_bad++;
            $display("FAIL wr_strobe: got count=%0d at=%0d expected 1 at 5", wr_cnt, wr_idx);
        end
        n_cmp++;
        if (addr_at_stb !== 2'b01 || data_at_wr !== 8'hA5) begin
            n_bad++;
            $display("FAIL wr_payload: got addr=%b data=%h expected 01/A5", addr_at_stb, data_at_wr);
        end
        n_cmp++;
        if (rd_cnt !== 0 || err_cnt !== 0) begin
            n_bad++;
            $display("FAIL wr_other: got rd=%0d err=%0d expected 0/0", rd_cnt, err_cnt);
        end
        $display("write: addr=01 data=A5 wr_stb count=%0d at +%0d", wr_cnt, wr_idx);
    endtask

    task automatic test_read();
        clear_log();
        ziorq_n  = 1'b0;
        zrd_n    = 1'b0;
        port_sel = 1'b1;
        za_low   = 2'b10;
        ticks(8);
        bus_idle();
        ticks(8);
        n_cmp++;
        if (rd_cnt !== 1 || rd_idx !== 5) begin
            n_bad++;
            $display("FAIL rd_strobe: got count=%0d at=%0d expected 1 at 5", rd_cnt, rd_idx);
        end
        n_cmp++;
        if (addr_at_stb !== 2'b10) begin
            n_bad++;
            $display("FAIL rd_addr: got %b expected 10", addr_at_stb);
        end
        n_cmp++;
        if (wr_cnt !== 0 || cyc_active !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_other: got wr=%0d active=%b expected 0/0", wr_cnt, cyc_active);
        end
        $display("read: addr=10 rd_stb count=%0d at +%0d", rd_cnt, rd_idx);
    endtask

    task automatic test_glitch();
        clear_log();
        ziorq_n  = 1'b0;
        zwr_n    = 1'b0;
        port_sel = 1'b1;
        za_low   = 2'b00;
        zd_in    = 8'h00;
        tick();
        bus_idle();
        ticks(8);
        n_cmp++;
        if (wr_cnt !== 0 || act_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_idle: got wr=%0d active_seen=%b expected 0/0", wr_cnt, act_seen);
        end
        clear_log();
        ziorq_n  = 1'b0;
        zwr_n    = 1'b0;
        port_sel = 1'b1;
        za_low   = 2'b11;
        zd_in    = 8'h11;
        ticks(7);
        // WR bounces high for a single sample in the middle of the write.
        zwr_n = 1'b1;
        tick();
        zwr_n = 1'b0;
        ticks(5);
        n_cmp++;
        if (wr_cnt !== 0 || cyc_active !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_mid: got wr=%0d active=%b expected 0/1", wr_cnt, cyc_active);
        end
        bus_idle();
        idx = 0;
        ticks(8);
        n_cmp++;
        if (wr_cnt !== 1 || wr_idx !== 5 || data_at_wr !== 8'h11) begin
            n_bad++;
            $display("FAIL glitch_end: got count=%0d at=%0d data=%h expected 1 at 5 data 11",
                     wr_cnt, wr_idx, data_at_wr);
        end
        $display("glitch: idle glitch ignored, mid-write bounce gave %0d wr_stb", wr_cnt);
    endtask

    task automatic test_data_change();
        clear_log();
        ziorq_n  = 1'b0;
        zwr_n    = 1'b0;
        port_sel = 1'b1;
        za_low   = 2'b00;
        zd_in    = 8'h5A;
        ticks(6);
        zd_in = 8'hC3;
        tick();
        bus_idle();
        idx = 0;
        ticks(8);
        n_cmp++;
        if (wr_cnt !== 1 || data_at_wr !== 8'hC3) begin
            n_bad++;
            $display("FAIL late_data: got count=%0d data=%h expected 1/C3", wr_cnt, data_at_wr);
        end
        $display("late data: wr_stb data=%h", data_at_wr);
    endtask

    task automatic test_conflict();
        clear_log();
        ziorq_n  = 1'b0;
        zrd_n    = 1'b0;
        zwr_n    = 1'b0;
        port_sel = 1'b1;
        za_low   = 2'b01;
        ticks(8);
        n_cmp++;
        if (err_cnt !== 1 || err_idx !== 5 || cyc_active !== 1'b1) begin
            n_bad++;
            $display("FAIL err_pulse: got count=%0d at=%0d active=%b expected 1 at 5 active 1",
                     err_cnt, err_idx, cyc_active);
        end
        zrd_n = 1'b1;
        ticks(6);
        n_cmp++;
        if (cyc_active !== 1'b1 || err_cnt !== 1) begin
            n_bad++;
            $display("FAIL err_hold: got active=%b err=%0d expected 1/1", cyc_active, err_cnt);
        end
        bus_idle();
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (idx == 4) begin
                n_cmp++;
                if (cyc_active !== 1'b1) begin
                    n_bad++;
                    $display("FAIL err_release_early: got %b expected 1", cyc_active);
                end
            end
            if (idx == 5) begin
                n_cmp++;
                if (cyc_active !== 1'b0) begin
                    n_bad++;
                    $display("FAIL err_release: got %b expected 0", cyc_active);
                end
            end
        end
        n_cmp++;
        if (rd_cnt !== 0 || wr_cnt !== 0 || err_cnt !== 1) begin
            n_bad++;
            $display("FAIL err_strobes: got rd=%0d wr=%0d err=%0d expected 0/0/1", rd_cnt, wr_cnt, err_cnt);
        end
        $display("conflict: cyc_err count=%0d, rd=%0d wr=%0d", err_cnt, rd_cnt, wr_cnt);
    endtask

    task automatic test_reset_mid_write();
        clear_log();
        ziorq_n  = 1'b0;
        zwr_n    = 1'b0;
        port_sel = 1'b1;
        za_low   = 2'b11;
        zd_in    = 8'h77;
        ticks(8);
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({cyc_active, stb_addr, stb_data} !== 11'd0) begin
            n_bad++;
            $display("FAIL midrst_state: got active=%b addr=%b data=%h expected all 0",
                     cyc_active, stb_addr, stb_data);
        end
        rst = 1'b0;
        ticks(6);
        bus_idle();
        ticks(10);
        n_cmp++;
        if (wr_cnt !== 0 || cyc_active !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_nostrobe: got wr=%0d active=%b expected 0/0", wr_cnt, cyc_active);
        end
        clear_log();
        ziorq_n  = 1'b0;
        zwr_n    = 1'b0;
        port_sel = 1'b1;
        za_low   = 2'b01;
        zd_in    = 8'h3C;
        ticks(6);
        bus_idle();
        idx = 0;
        ticks(8);
        n_cmp++;
        if (wr_cnt !== 1 || wr_idx !== 5 || data_at_wr !== 8'h3C || addr_at_stb !== 2'b01) begin
            n_bad++;
            $display("FAIL midrst_next: got count=%0d at=%0d data=%h addr=%b expected 1 at 5 3C 01",
                     wr_cnt, wr_idx, data_at_wr, addr_at_stb);
        end
        $display("reset mid write: aborted cycle silent, next write count=%0d", wr_cnt);
    endtask

    task automatic test_back_to_back();
        clear_log();
        ziorq_n  = 1'b0;
        zrd_n    = 1'b0;
        port_sel = 1'b1;
        za_low   = 2'b10;
        ticks(6);
        zrd_n = 1'b1;
        idx   = 0;
        ticks(2);
        zrd_n = 1'b0;
        ticks(5);
        n_cmp++;
        if (rd_cnt !== 2 || rd_idx !== 7) begin
            n_bad++;
            $display("FAIL b2b_second: got count=%0d at=%0d expected 2 at 7", rd_cnt, rd_idx);
        end
        bus_idle();
        ticks(8);
        n_cmp++;
        if (rd_cnt !== 2 || wr_cnt !== 0 || ovl_cnt !== 0) begin
            n_bad++;
            $display("FAIL b2b_total: got rd=%0d wr=%0d overlap=%0d expected 2/0/0", rd_cnt, wr_cnt, ovl_cnt);
        end
        $display("back to back: rd_stb count=%0d", rd_cnt);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_glitch();
        test_data_change();
        test_conflict();
        test_reset_mid_write();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
